// File: rtl/bram_pkg.sv
// bram_pkg: shared types and widths for the BRAM sample streamer
package bram_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} stream_state_t;
    localparam int BRAM_WORD_W        = 32;
    localparam int BRAM_WE_W          = 4;
    localparam int DEFAULT_BRAM_DELAY = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, power-of-2 depth
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, do_wr, do_rd;

    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // pointer and occupancy updates; a write into a full FIFO is allowed only alongside a read
    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    // control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset; empty gates everything read out of it
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/bram_sample_streamer.sv
// bram_sample_streamer: streams a BRAM sample buffer onto an AXI-Stream master with credit flow control
module bram_sample_streamer
    import bram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'd0,
    parameter int          NUM_WORDS      = 256,
    parameter int          BRAM_DELAY     = DEFAULT_BRAM_DELAY,
    parameter logic [31:0] ADDR_INCREMENT = 32'd1,
    parameter int          FIFO_DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   loop_en,
    output logic [BRAM_WORD_W-1:0] BRAM_addr,
    output logic                   BRAM_clk,
    output logic [BRAM_WORD_W-1:0] BRAM_din,
    input  logic [BRAM_WORD_W-1:0] BRAM_dout,
    output logic                   BRAM_en,
    output logic                   BRAM_rst,
    output logic [BRAM_WE_W-1:0]   BRAM_we,
    output logic [BRAM_WORD_W-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   busy,
    output logic [15:0]            underrun_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    stream_state_t          state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [BRAM_DELAY-1:0]  pv_q, pv_d, pl_q, pl_d;
    logic [15:0]            underrun_q, underrun_d;
    logic                   bram_rst_q;
    logic [CW-1:0]          fifo_count, inflight;
    logic [CW:0]            used;
    logic                   fifo_empty, credit_ok, last_word, issue, pop;
    logic [BRAM_WORD_W:0]   fifo_rd_data;

    assign BRAM_clk     = clk;
    assign BRAM_din     = '0;
    assign BRAM_we      = '0;
    assign BRAM_addr    = addr_q;
    assign BRAM_en      = issue;
    assign BRAM_rst     = bram_rst_q;
    assign m_tvalid     = !fifo_empty;
    assign m_tdata      = fifo_empty ? '0 : fifo_rd_data[BRAM_WORD_W-1:0];
    assign m_tlast      = !fifo_empty && fifo_rd_data[BRAM_WORD_W];
    assign busy         = state_q != IDLE;
    assign underrun_cnt = underrun_q;
    assign pop          = m_tvalid && m_tready;

    // a read may issue only if its word is guaranteed a FIFO slot when it lands
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_DELAY; i++) inflight = inflight + CW'(pv_q[i]);
        used      = {1'b0, fifo_count} + {1'b0, inflight};
        credit_ok = used < (CW+1)'(FIFO_DEPTH);
        last_word = idx_q == IW'(NUM_WORDS - 1);
    end

    // stream FSM with address/index counters and read issue
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    addr_d  = BASE_ADDR;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    issue   = 1'b1;
                    addr_d  = last_word ? BASE_ADDR : addr_q + ADDR_INCREMENT;
                    idx_d   = last_word ? '0 : idx_q + IW'(1);
                    state_d = (last_word && !loop_en) ? DRAIN : RUN;
                end
            end
            default: begin
                if (pv_q == '0 && fifo_empty) state_d = IDLE;
            end
        endcase
    end

    // read-latency tracking pipe and saturating underrun counter
    always_comb begin
        pv_d       = (pv_q << 1) | BRAM_DELAY'(issue);
        pl_d       = (pl_q << 1) | BRAM_DELAY'(issue && last_word);
        underrun_d = (state_q == RUN && m_tready && fifo_empty && underrun_q != 16'hFFFF) ? underrun_q + 16'd1 : underrun_q;
    end

    // state registers; BRAM_rst follows reset and drops on the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= BASE_ADDR;
            idx_q      <= '0;
            pv_q       <= '0;
            pl_q       <= '0;
            underrun_q <= '0;
            bram_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            pv_q       <= pv_d;
            pl_q       <= pl_d;
            underrun_q <= underrun_d;
            bram_rst_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (BRAM_WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pv_q[BRAM_DELAY-1]),
        .wr_data ({pl_q[BRAM_DELAY-1], BRAM_dout}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
endmodule
